// File: rtl/ps2_kbd_ctrl_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard controller slice.
//   - controller state encoding (OFF / WAIT / DECODE, 2 bits)
//   - scan-code set 2 constants for prefixes and non-key codes
//   - event word width: {extended, release, code[7:0]}
//   - is_ignored(): true for BAT/ack/echo/error bytes that carry no key
package ps2_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    WAIT   = 2'd1,
    DECODE = 2'd2
  } state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_ECHO  = 8'hEE;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;

  localparam int EVT_W = 10;

  // Bytes that are dropped when no prefix is pending.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// ps2_kbd_ctrl_if: key-event handshake between the controller and its consumer.
//   evt_valid    head event present (FIFO not empty)
//   evt_ready    consumer accepts the head event
//   evt_code     head scan code, prefixes stripped
//   evt_extended head event was preceded by E0
//   evt_release  head event was preceded by F0
//   evt_count    FIFO occupancy, 0..FIFO_DEPTH
// Modports: master = controller side, slave = consumer side.
interface ps2_kbd_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          evt_valid;
  logic          evt_ready;
  logic [7:0]    evt_code;
  logic          evt_extended;
  logic          evt_release;
  logic [CW-1:0] evt_count;

  modport master (
    output evt_valid, evt_code, evt_extended, evt_release, evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_extended, evt_release, evt_count,
    output evt_ready
  );
endinterface

// File: rtl/ps2_kbd_ctrl_evt_fifo.sv
// ps2_evt_fifo: synchronous first-word-fall-through FIFO for key events.
//   clk, rst  clock, synchronous active-low reset (empties the FIFO)
//   push, din write request and data; refused when full unless popping
//   pop       read request; ignored when empty
//   dout      head entry (valid while !empty)
//   full, empty, count  status; count ranges 0..DEPTH
// Overflow reporting is left to the instantiating controller.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // Accept/refuse decisions and next pointer/occupancy values.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == CW'(0));
    rd_en_s  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    wr_en_s  = push && (!full || rd_en_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    dout  = mem_q[rd_ptr_q];
    count = count_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: arms the PS/2 byte receiver, decodes scan-code set 2
// prefixes (E0 extended, F0 break) into single key events and queues
// them in an event FIFO for the consumer.
//   clk, rst             clock, synchronous active-low reset
//   enable               1 = arm the receiver, 0 = park in OFF
//   byte_data            received byte, valid with full_byte_received
//   full_byte_received   one-cycle pulse from the receiver
//   wait_for_data        arms the receiver's start-bit wait
//   start_receiving_data tied 0
//   evt                  event handshake (ps2_kbd_ctrl_if.master)
//   overflow             sticky, an event was dropped on a full FIFO
//   clr_overflow         clears overflow (a same-cycle drop wins)
// Optional build macro PS2_PREFIX_TIMEOUT_EN: pending prefixes are
// abandoned after TIMEOUT_CYCLES clocks without a completing byte.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [7:0]            byte_data,
  input  logic                  full_byte_received,
  output logic                  wait_for_data,
  output logic                  start_receiving_data,
  ps2_kbd_ctrl_if.master        evt,
  output logic                  overflow,
  input  logic                  clr_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             ovf_q, ovf_d;
  logic             wait_q, wait_d;
  logic             push_s;
  logic             pop_s;
  logic [EVT_W-1:0] evt_word_s;
  logic [EVT_W-1:0] head_s;
  logic             full_s;
  logic             empty_s;
  logic [CW-1:0]    count_s;
  logic             tmo_exp_s;

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_run_q, tmo_run_d;
  logic          prefix_set_s;

  // Prefix timeout: started by a prefix, stopped by a push, fires once.
  always_comb begin
    prefix_set_s = (state_q == DECODE) && ((byte_q == SC_EXT) || (byte_q == SC_BREAK));
    tmo_exp_s    = tmo_run_q && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    tmo_run_d    = tmo_run_q;
    tmo_cnt_d    = tmo_cnt_q;
    if (push_s) begin
      tmo_run_d = 1'b0;
      tmo_cnt_d = TW'(0);
    end else if (prefix_set_s) begin
      tmo_run_d = 1'b1;
      tmo_cnt_d = TW'(0);
    end else if (tmo_exp_s) begin
      tmo_run_d = 1'b0;
      tmo_cnt_d = TW'(0);
    end else if (tmo_run_q) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Prefix timeout registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_run_q <= 1'b0;
      tmo_cnt_q <= TW'(0);
    end else begin
      tmo_run_q <= tmo_run_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Prefixes never expire in this build.
  always_comb begin
    tmo_exp_s = 1'b0;
  end
`endif

  // Controller FSM next state, byte capture and prefix decode.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    push_s     = 1'b0;
    evt_word_s = {ext_q, brk_q, byte_q};
    if (tmo_exp_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else begin
      ext_d = ext_q;
      brk_d = brk_q;
    end
    case (state_q)
      OFF: begin
        if (enable) begin
          state_d = WAIT;
        end else begin
          state_d = OFF;
        end
      end
      WAIT: begin
        // A byte in flight takes priority over dropping enable.
        if (full_byte_received) begin
          byte_d  = byte_data;
          state_d = DECODE;
        end else if (!enable) begin
          state_d = OFF;
        end else begin
          state_d = WAIT;
        end
      end
      DECODE: begin
        if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == SC_BREAK) begin
          brk_d = 1'b1;
        end else if (!ext_q && !brk_q && is_ignored(byte_q)) begin
          push_s = 1'b0;
        end else begin
          push_s = 1'b1;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end
        if (enable) begin
          state_d = WAIT;
        end else begin
          state_d = OFF;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
    wait_d = (state_d == WAIT);
  end

  // Pop handshake and sticky overflow; a drop in the clear cycle wins.
  always_comb begin
    pop_s = !empty_s && evt.evt_ready;
    if (push_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= OFF;
      byte_q  <= 8'h00;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      ovf_q   <= ovf_d;
      wait_q  <= wait_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (evt_word_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Output drive; the head is masked so stale storage never shows when empty.
  always_comb begin
    wait_for_data        = wait_q;
    start_receiving_data = 1'b0;
    overflow             = ovf_q;
    evt.evt_valid        = !empty_s;
    evt.evt_count        = count_s;
    if (empty_s) begin
      evt.evt_code     = 8'h00;
      evt.evt_extended = 1'b0;
      evt.evt_release  = 1'b0;
    end else begin
      evt.evt_code     = head_s[7:0];
      evt.evt_extended = head_s[9];
      evt.evt_release  = head_s[8];
    end
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Sequences the PS/2 byte receiver. It arms the receiver, collects each received byte, and decodes scan-code set 2 prefixes (E0 extended, F0 break) into single key events. Events are queued in a small FIFO for the consumer, e.g. the CPU keyboard I/O register or an interrupt source. It sits between the receiver and the memory-mapped keyboard port.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
TIMEOUT_CYCLES, 2500000, clk cycles allowed between prefix and final byte (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
enable  in  1  1 = controller arms the receiver; 0 = controller parks in OFF
byte_data  in  8  received byte from the receiver
full_byte_received  in  1  one-cycle pulse from the receiver; byte_data is valid in this cycle
wait_for_data  out  1  arms the receiver's start-bit wait
start_receiving_data  out  1  tied 0 (start-bit detection is always used)
evt_valid  out  1  FIFO not empty
evt_ready  in  1  consumer accepts the head event
evt_code  out  8  head event scan code (prefix stripped)
evt_extended  out  1  head event preceded by E0
evt_release  out  1  head event preceded by F0
evt_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; an event was dropped because the FIFO was full
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (rst==0 at clk edge):
  - state=OFF, FIFO emptied, ext_pend=0, brk_pend=0, overflow=0.
  - All outputs 0.
  - Reset mid-frame discards any pending prefix and any partial event.
- FSM states (encoded 2-bit):
  - OFF: wait_for_data=0. Goes to WAIT when enable=1.
  - WAIT: wait_for_data=1. When full_byte_received=1, byte_data is latched into byte_q and the state goes to DECODE. When enable=0 and no pulse is present, the state goes to OFF; pending flags are kept.
  - DECODE (one cycle): wait_for_data=0. Classifies byte_q, then goes to WAIT if enable=1, otherwise to OFF.
- Decode rules, applied in the DECODE cycle:
  - byte_q==E0: ext_pend<=1.
  - byte_q==F0: brk_pend<=1.
  - byte_q in {AA, FA, EE, 00, FF} with no prefix pending: ignored (BAT/ack/echo/error codes).
  - Any other byte, or any byte with a prefix pending: push {ext_pend, brk_pend, byte_q}, then clear both pend flags.
- Latency: if full_byte_received is high in cycle T, evt_valid is high at T+2 (FIFO previously empty).
- FIFO behaviour:
  - First-word-fall-through; evt_* outputs show the head entry.
  - Pop occurs when evt_valid && evt_ready.
  - Push when full with no pop in the same cycle: the event is dropped and overflow<=1.
  - Push when full with a pop in the same cycle: both happen, count is unchanged, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; evt_count ranges 0..FIFO_DEPTH.
  - clr_overflow clears overflow. If a drop occurs in the same cycle, set wins.
- A full_byte_received pulse arriving while not in WAIT is ignored. The receiver cannot produce one outside WAIT.
- evt_ready is ignored while rst==0.

Optional Feature:
Macro PS2_PREFIX_TIMEOUT_EN.
- With the macro defined:
  - A counter starts when a DECODE sets ext_pend or brk_pend.
  - The counter is cleared on the next push or on reset.
  - When the counter reaches TIMEOUT_CYCLES, both pend flags are cleared and nothing is pushed.
  - Recovers from a lost byte mid-sequence.
- Without the macro: no counter exists, and prefixes stay pending indefinitely.

Decomposition:
Shared package ps2_pkg contains:
- state encoding constants OFF/WAIT/DECODE
- scan-code constants SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_BAT=8'hAA, SC_ACK=8'hFA, SC_ECHO=8'hEE, SC_ERR0=8'h00, SC_ERR1=8'hFF
- event width constant EVT_W=10

One sub-module, ps2_evt_fifo:
- synchronous FIFO, parameterised on depth and width
- push/pop/full/empty/count ports
- no overflow logic (that stays in the controller)

Test Plan:
1. enable=1, byte 1C (A make) -> evt_valid at T+2 with code=1C, ext=0, rel=0; evt_count=1.
2. Bytes F0, 1C -> exactly one event: code=1C, rel=1, ext=0. Bytes E0, F0, 75 -> code=75, ext=1, rel=1.
3. Byte AA, then FA -> no events; evt_count stays 0. Then F0, AA -> event code=AA, rel=1.
4. FIFO_DEPTH=4, evt_ready=0, send 5 make codes -> evt_count=4, overflow=1, head=first code. Pop with clr_overflow -> overflow=0. Push with a simultaneous pop while full -> no drop.
5. rst=0 asserted after E0 is received, then release and send 1C -> event ext=0. Drop enable while in WAIT -> wait_for_data=0 next cycle.
6. With PS2_PREFIX_TIMEOUT_EN and TIMEOUT_CYCLES=100: send E0, idle 100 cycles, send 1C -> ext=0. Without the macro, the same stimulus gives ext=1.
